// File: rtl/pixel_frame_loader.sv
// Serial-to-parallel loader for the 3x3 binary-pixel mean stage: assembles
// nine pixels, publishes them on X_0..X_8 and holds them until acknowledged.
module pixel_frame_loader #(
  parameter int N_PIX = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic             X_0,
  output logic             X_1,
  output logic             X_2,
  output logic             X_3,
  output logic             X_4,
  output logic             X_5,
  output logic             X_6,
  output logic             X_7,
  output logic             X_8,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_count
);

  localparam int IDX_W = $clog2(N_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [N_PIX-1:0] staging_reg;
  logic [N_PIX-1:0] x_reg;
  logic             frame_valid_reg;
  logic             frame_err_reg;
  logic [CNT_W-1:0] frame_count_reg;
  logic             ready_reg;
  logic             transfer;

  // ready is a register so it can stay low while rst is held and rise one
  // clock after release, independent of any input.
  assign transfer = pix_valid & ready_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      staging_reg     <= '0;
      x_reg           <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      frame_count_reg <= '0;
      ready_reg       <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (transfer) begin
            if (pix_sof) begin
              staging_reg[0] <= pix_in;
              idx_reg        <= IDX_W'(1);
              state_reg      <= ST_LOAD;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (transfer) begin
            if (pix_sof) begin
              // restart: the new sof pixel becomes pixel 0 of a fresh frame
              frame_err_reg  <= 1'b1;
              staging_reg[0] <= pix_in;
              idx_reg        <= IDX_W'(1);
            end else if (idx_reg == LAST_IDX) begin
              x_reg           <= {pix_in, staging_reg[N_PIX-2:0]};
              frame_valid_reg <= 1'b1;
              ready_reg       <= 1'b0;
              idx_reg         <= '0;
              state_reg       <= ST_HOLD;
            end else begin
              staging_reg[idx_reg] <= pix_in;
              idx_reg              <= idx_reg + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (frame_ack) begin
            frame_valid_reg <= 1'b0;
            frame_count_reg <= frame_count_reg + CNT_W'(1);
            ready_reg       <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign pix_ready   = ready_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_err   = frame_err_reg;
  assign frame_count = frame_count_reg;
  assign X_0 = x_reg[0];
  assign X_1 = x_reg[1];
  assign X_2 = x_reg[2];
  assign X_3 = x_reg[3];
  assign X_4 = x_reg[4];
  assign X_5 = x_reg[5];
  assign X_6 = x_reg[6];
  assign X_7 = x_reg[7];
  assign X_8 = x_reg[8];

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Scoreboard bench for pixel_frame_loader: the driver feeds a pixel-list
// reference model that schedules expected events; a negedge monitor checks them.
module tb_pixel_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_in = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       frame_ack = 1'b0;
  logic       pix_ready;
  logic       X_0, X_1, X_2, X_3, X_4, X_5, X_6, X_7, X_8;
  logic       frame_valid;
  logic       frame_err;
  logic [7:0] frame_count;
  logic [8:0] x_bus;

  pixel_frame_loader #(.N_PIX(9), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .X_0(X_0), .X_1(X_1), .X_2(X_2), .X_3(X_3), .X_4(X_4),
    .X_5(X_5), .X_6(X_6), .X_7(X_7), .X_8(X_8),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  assign x_bus = {X_8, X_7, X_6, X_5, X_4, X_3, X_2, X_1, X_0};

  typedef struct { int cyc; logic [8:0] bits; } frm_ev_t;
  typedef struct { int cyc; logic [7:0] val; } cnt_ev_t;
  frm_ev_t frm_q[$];
  cnt_ev_t cnt_q[$];
  int      err_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // reference model: pixels gathered since the last sof
  int         model_cnt;
  logic [8:0] model_bits;
  bit         model_hold;
  logic [7:0] model_count;

  // what the outputs should currently show
  bit         mon_en = 1'b0;
  logic [8:0] mon_x;
  bit         mon_fv;
  logic [7:0] mon_count;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit      exp_err;
      frm_ev_t fe;
      cnt_ev_t ce;
      exp_err = (err_q.size() > 0 && err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      if (frm_q.size() > 0 && frm_q[0].cyc == cyc) begin
        fe = frm_q.pop_front();
        mon_x  = fe.bits;
        mon_fv = 1'b1;
      end
      if (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
        ce = cnt_q.pop_front();
        mon_count = ce.val;
        mon_fv    = 1'b0;
      end
      check("mon_frame_err", frame_err, exp_err);
      check("mon_frame_valid", frame_valid, mon_fv);
      check("mon_x", x_bus, mon_x);
      check("mon_frame_count", frame_count, mon_count);
      check("mon_pix_ready", pix_ready, !mon_fv);
    end
  end

  task automatic model_accept(input bit sof, input bit pix);
    if (sof) begin
      if (model_cnt != 0) err_q.push_back(cyc + 1);
      model_bits    = '0;
      model_bits[0] = pix;
      model_cnt     = 1;
    end else if (model_cnt == 0) begin
      err_q.push_back(cyc + 1);
    end else begin
      model_bits[model_cnt] = pix;
      model_cnt++;
      if (model_cnt == 9) begin
        frm_q.push_back('{cyc: cyc + 1, bits: model_bits});
        model_cnt  = 0;
        model_hold = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one cycle of pix_valid; the loader takes it unless a frame is held
  task automatic drive_pix(input bit sof, input bit pix);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_in    = pix;
    if (!model_hold) model_accept(sof, pix);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] bits, input int max_gap);
    for (int i = 0; i < 9; i++) begin
      drive_pix(i == 0, bits[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    if (model_hold) begin
      model_count++;
      cnt_q.push_back('{cyc: cyc + 1, val: model_count});
      model_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  // asserted between clock edges; outputs are checked before any edge occurs
  task automatic do_reset();
    mon_en    = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    frame_ack = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_x", x_bus, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_count", frame_count, 0);
    frm_q.delete();
    cnt_q.delete();
    err_q.delete();
    model_cnt   = 0;
    model_bits  = '0;
    model_hold  = 1'b0;
    model_count = '0;
    mon_x       = '0;
    mon_fv      = 1'b0;
    mon_count   = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] fixed;
    logic [8:0] rnd;
    @(posedge clk);
    #1;
    do_reset();

    // back-to-back frame 1,0,1,1,0,0,1,0,1
    fixed = 9'b101001101;
    for (int i = 0; i < 9; i++) drive_pix(i == 0, fixed[i]);
    check("t1_frame_valid", frame_valid, 1);
    check("t1_x", x_bus, fixed);
    check("t1_pix_ready", pix_ready, 0);

    // hold for 5 cycles, then acknowledge
    idle(5);
    do_ack();
    check("t2_frame_valid", frame_valid, 0);
    check("t2_frame_count", frame_count, 1);
    check("t2_pix_ready", pix_ready, 1);
    check("t2_x_kept", x_bus, fixed);

    // partial frame aborted by a new sof
    drive_pix(1'b1, 1'($urandom));
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'($urandom));
    check("t3_x_undisturbed", x_bus, fixed);
    drive_pix(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) drive_pix(1'b0, 1'b0);
    check("t3_x", x_bus, 9'b000000001);
    do_ack();

    // stray pixels in IDLE
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'($urandom));
    check("t4_frame_valid", frame_valid, 0);
    check("t4_x", x_bus, 9'b000000001);

    // gapped frame with a stray ack in the middle
    rnd = 9'($urandom);
    for (int i = 0; i < 9; i++) begin
      drive_pix(i == 0, rnd[i]);
      idle($urandom_range(0, 7));
      if (i == 4) do_ack();
    end
    check("t5_x", x_bus, rnd);
    check("t5_frame_count", frame_count, 2);
    do_ack();

    // async reset mid-load after 5 pixels, then 256 frames to wrap the counter
    for (int i = 0; i < 5; i++) drive_pix(i == 0, 1'b1);
    do_reset();
    for (int f = 0; f < 256; f++) begin
      send_frame(9'($urandom), 0);
      do_ack();
    end
    check("t6_count_wrap", frame_count, 0);

    // random mix: sof restarts, stray pixels, gaps, pixels offered during HOLD
    for (int i = 0; i < 300; i++) begin
      if (model_hold && $urandom_range(0, 3) == 0) do_ack();
      else drive_pix($urandom_range(0, 7) == 0, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    if (model_hold) do_ack();
    idle(3);
    check("pending_events", err_q.size() + frm_q.size() + cnt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
